// File: rtl/tone_pkg.sv
// Shared types and constants for the tone arbiter and its sine-generator front end.
package tone_pkg;

  // Arbiter sequencing states
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PLAY = 2'd1,
    GAP  = 2'd2
  } tone_state_t;

  // Default sizing, matching the phase-accumulator sine generator
  localparam int TONE_NUM_REQ   = 4;
  localparam int TONE_PHASE_W   = 32;
  localparam int TONE_DUR_W     = 20;
  localparam int TONE_GAP_TICKS = 48;

  // Phase increments for standard notes at 48 kHz, 24-bit phase scaling:
  // inc = round_down(f * 2^24 / 48000)
  localparam logic [TONE_PHASE_W-1:0] NOTE_440_INC  = 32'h0002_58BF;
  localparam logic [TONE_PHASE_W-1:0] NOTE_880_INC  = 32'h0004_B17E;
  localparam logic [TONE_PHASE_W-1:0] NOTE_1320_INC = 32'h0007_0A3D;

endpackage

// File: rtl/tone_arbiter_rr_arbiter.sv
// Generic combinational round-robin arbiter: grants the first requester at or
// after ptr, wrapping around, as a one-hot vector.
module rr_arbiter #(
  parameter int N = 4,
  localparam int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  grant
);

  int idx;

  // Scan from farthest to nearest so the nearest valid request after ptr wins
  always_comb begin
    grant = '0;
    idx   = 0;
    for (int k = N - 1; k >= 0; k--) begin
      idx = (int'(ptr) + k) % N;
      if (req[idx]) begin
        grant = '0;
        grant[idx] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/tone_arbiter.sv
// Time-shares one sine generator between several note requesters: round-robin
// grant, plays the winner's tone for its duration in sample ticks, then a gap.
module tone_arbiter
  import tone_pkg::*;
#(
  parameter int NUM_REQ   = TONE_NUM_REQ,
  parameter int PHASE_W   = TONE_PHASE_W,
  parameter int DUR_W     = TONE_DUR_W,
  parameter int GAP_TICKS = TONE_GAP_TICKS,
  localparam int IDW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       sample_tick,
  input  logic [NUM_REQ-1:0]         req_valid,
  output logic [NUM_REQ-1:0]         req_ready,
  input  logic [NUM_REQ*PHASE_W-1:0] req_phase_inc,
  input  logic [NUM_REQ*DUR_W-1:0]   req_dur,
  input  logic                       abort,
  output logic [PHASE_W-1:0]         gen_phase_inc,
  output logic                       gen_enable,
  output logic [IDW-1:0]             grant_id,
  output logic                       busy,
  output logic                       note_done
);

  localparam logic [DUR_W-1:0] GAP_CNT = DUR_W'(GAP_TICKS);

  tone_state_t          state;
  logic [IDW-1:0]       ptr;
  logic [DUR_W-1:0]     count;
  logic [NUM_REQ-1:0]   grant;
  logic                 grant_any;
  logic [IDW-1:0]       win_idx;
  logic [PHASE_W-1:0]   win_inc;
  logic [DUR_W-1:0]     win_dur;

  rr_arbiter #(.N(NUM_REQ)) u_rr (
    .req   (req_valid),
    .ptr   (ptr),
    .grant (grant)
  );

  // Decode the one-hot winner into an index and select its request fields
  always_comb begin
    win_idx = '0;
    win_inc = '0;
    win_dur = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) begin
        win_idx = IDW'(i);
        win_inc = req_phase_inc[i*PHASE_W +: PHASE_W];
        win_dur = req_dur[i*DUR_W +: DUR_W];
      end
    end
  end

  // Accept only while idle; held low while reset is asserted
  always_comb begin
    grant_any = |grant;
    req_ready = (state == IDLE && !reset) ? grant : '0;
  end

  assign busy = (state != IDLE);

  // Sequencer: grant, play for dur ticks, silent gap, back to idle
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      ptr           <= '0;
      count         <= '0;
      gen_phase_inc <= '0;
      gen_enable    <= 1'b0;
      grant_id      <= '0;
      note_done     <= 1'b0;
    end else begin
      note_done <= 1'b0;
      case (state)
        IDLE: begin
          if (grant_any) begin
            gen_phase_inc <= win_inc;
            grant_id      <= win_idx;
            ptr           <= (win_idx == IDW'(NUM_REQ - 1)) ? '0 : win_idx + IDW'(1);
            if (win_dur != '0) begin
              state      <= PLAY;
              count      <= win_dur;
              gen_enable <= 1'b1;
            end else begin
              state     <= GAP;
              count     <= GAP_CNT;
              note_done <= 1'b1;
            end
          end
        end
        PLAY: begin
          if (abort) begin
            state      <= IDLE;
            count      <= '0;
            gen_enable <= 1'b0;
          end else if (sample_tick) begin
            if (count == DUR_W'(1)) begin
              state      <= GAP;
              count      <= GAP_CNT;
              gen_enable <= 1'b0;
              note_done  <= 1'b1;
            end else begin
              count <= count - DUR_W'(1);
            end
          end
        end
        GAP: begin
          if (abort || count == '0) begin
            state <= IDLE;
            count <= '0;
          end else if (sample_tick) begin
            count <= count - DUR_W'(1);
          end
        end
        default: begin
          state      <= IDLE;
          gen_enable <= 1'b0;
        end
      endcase
    end
  end

endmodule
